// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: demand-driven phase scheduler for a four-road intersection.
// Latches vehicle and pedestrian requests, grants road greens round-robin within
// min/max green limits and interleaves pedestrian walk phases.
// Ports:
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   veh_req[3:0]        - vehicle detectors, bit i = road i+1
//   ped_req[3:0]        - crossing push buttons, bit i = crossing over road i+1
//   rd1..rd4            - road lights {red,yellow,green}
//   rd1c..rd4c          - crossing lights {red,clear,walk}
//   count               - phase timer
//   phase               - state code
//   road                - index of the last granted road
module traffic_phase_scheduler #(
   parameter int unsigned MIN_GREEN = 4,
   parameter int unsigned MAX_GREEN = 10,
   parameter int unsigned YELLOW    = 2,
   parameter int unsigned ALL_RED   = 1,
   parameter int unsigned WALK      = 6,
   parameter int unsigned PED_CLR   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] veh_req,
   input  logic [3:0] ped_req,
   output logic [2:0] rd1,
   output logic [2:0] rd2,
   output logic [2:0] rd3,
   output logic [2:0] rd4,
   output logic [2:0] rd1c,
   output logic [2:0] rd2c,
   output logic [2:0] rd3c,
   output logic [2:0] rd4c,
   output logic [3:0] count,
   output logic [2:0] phase,
   output logic [1:0] road
);

   typedef enum logic [2:0] {
      S_ALLRED = 3'b000,
      S_GREEN  = 3'b001,
      S_YELLOW = 3'b010,
      S_WALK   = 3'b011,
      S_PCLR   = 3'b100
   } state_t;

   localparam logic [2:0] L_RED    = 3'b100;
   localparam logic [2:0] L_YELLOW = 3'b010;
   localparam logic [2:0] L_GREEN  = 3'b001;

   state_t     state;
   logic [3:0] veh_pend;
   logic [3:0] ped_pend;
   logic [3:0] walk_mask;
   logic       ped_last;

   logic [3:0] road_bit;
   logic [3:0] veh_in;
   logic [1:0] grant;
   logic       other_dem;
   logic       done;

   // Next-grant search, demand test and end-of-phase detection
   always_comb begin
      road_bit  = 4'b0001 << road;
      veh_in    = veh_req;
      grant     = road + 2'd1;
      other_dem = ((veh_pend & ~road_bit) != 4'd0) || (ped_pend != 4'd0);
      done      = 1'b0;
      // The granted road's own detector is meaningless while it already has right of way
      if (state == S_GREEN || state == S_YELLOW)
         veh_in = veh_req & ~road_bit;
      // Descending scan so the nearest road after the current one wins
      for (int k = 4; k >= 1; k--) begin
         if (veh_pend[2'(road + 2'(k))])
            grant = 2'(road + 2'(k));
      end
      case (state)
         S_ALLRED: done = (count == 4'(ALL_RED - 1));
         S_GREEN:  done = (count == 4'(MAX_GREEN - 1)) ||
                          ((count >= 4'(MIN_GREEN - 1)) && other_dem);
         S_YELLOW: done = (count == 4'(YELLOW - 1));
         S_WALK:   done = (count == 4'(WALK - 1));
         S_PCLR:   done = (count == 4'(PED_CLR - 1));
         default:  done = 1'b1;
      endcase
   end

   // Phase state machine, timer and request latches
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_ALLRED;
         count     <= 4'd0;
         road      <= 2'd3;
         veh_pend  <= 4'd0;
         ped_pend  <= 4'd0;
         walk_mask <= 4'd0;
         ped_last  <= 1'b0;
      end else begin
         veh_pend <= veh_pend | veh_in;
         ped_pend <= ped_pend | ped_req;
         count    <= count + 4'd1;
         if (done) begin
            count <= 4'd0;
            case (state)
               S_ALLRED: begin
                  if (ped_pend != 4'd0 && !ped_last) begin
                     state     <= S_WALK;
                     walk_mask <= ped_pend;
                     // Served bits clear, but a fresh press on this edge stays latched
                     ped_pend  <= ped_req;
                     ped_last  <= 1'b1;
                  end else begin
                     state    <= S_GREEN;
                     road     <= grant;
                     veh_pend <= (veh_pend | veh_in) & ~(4'b0001 << grant);
                     ped_last <= 1'b0;
                  end
               end
               S_GREEN:  state <= S_YELLOW;
               S_YELLOW: state <= S_ALLRED;
               S_WALK:   state <= S_PCLR;
               S_PCLR:   state <= S_ALLRED;
               default:  state <= S_ALLRED;
            endcase
         end
      end
   end

   function automatic logic [2:0] road_light(input state_t st, input logic [1:0] rd,
                                             input logic [1:0] idx);
      logic [2:0] l;
      l = L_RED;
      if (rd == idx && st == S_GREEN)  l = L_GREEN;
      if (rd == idx && st == S_YELLOW) l = L_YELLOW;
      return l;
   endfunction

   function automatic logic [2:0] cross_light(input state_t st, input logic sel);
      logic [2:0] l;
      l = L_RED;
      if (sel && st == S_WALK) l = L_GREEN;
      if (sel && st == S_PCLR) l = L_YELLOW;
      return l;
   endfunction

   // Light decode from registered state only
   assign rd1   = road_light(state, road, 2'd0);
   assign rd2   = road_light(state, road, 2'd1);
   assign rd3   = road_light(state, road, 2'd2);
   assign rd4   = road_light(state, road, 2'd3);
   assign rd1c  = cross_light(state, walk_mask[0]);
   assign rd2c  = cross_light(state, walk_mask[1]);
   assign rd3c  = cross_light(state, walk_mask[2]);
   assign rd4c  = cross_light(state, walk_mask[3]);
   assign phase = state;

endmodule
